// File: rtl/axi_adc_jesd204_capture_ctrl.sv
// Capture sequencer for the JESD204 ADC path: arm, trigger, holdoff, then pass exactly N
// valid beats to the DMA. No data storage; only adc_valid is gated per channel.
module axi_adc_jesd204_capture_ctrl #(
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter int unsigned LENGTH_WIDTH  = 16,
    parameter int unsigned HOLDOFF_WIDTH = 8
) (
    input  logic                     adc_clk,
    input  logic                     adc_rst,
    input  logic                     cfg_arm,
    input  logic                     cfg_abort,
    input  logic                     cfg_trig_mode,
    input  logic [LENGTH_WIDTH-1:0]  cfg_length,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic                     trigger,
    input  logic [NUM_CHANNELS-1:0]  adc_valid_in,
    input  logic                     adc_dovf,
    output logic [NUM_CHANNELS-1:0]  adc_valid_out,
    output logic                     capture_busy,
    output logic                     capture_done,
    output logic                     capture_ovf,
    output logic [LENGTH_WIDTH-1:0]  capture_count
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitTrig = 3'd1,
        StHoldoff  = 3'd2,
        StCapture  = 3'd3,
        StDone     = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic                     trigger_q;
    logic [LENGTH_WIDTH-1:0]  len_q, len_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [LENGTH_WIDTH-1:0]  count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     trig_edge;
    logic                     beat;

    assign trig_edge = trigger & ~trigger_q;
    assign beat      = |adc_valid_in;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_arm && !cfg_abort) begin
                    len_d   = cfg_length;
                    hold_d  = cfg_holdoff;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (cfg_trig_mode) begin
                        state_d = StWaitTrig;
                    end else if (cfg_holdoff != '0) begin
                        state_d = StHoldoff;
                        hcnt_d  = cfg_holdoff;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StWaitTrig: begin
                if (trig_edge) begin
                    if (hold_q != '0) begin
                        state_d = StHoldoff;
                        hcnt_d  = hold_q;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StHoldoff: begin
                // Counter holds the cycles remaining including the current one.
                if (hcnt_q <= HOLDOFF_WIDTH'(1)) begin
                    state_d = StCapture;
                end else begin
                    hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
                end
            end
            StCapture: begin
                if (adc_dovf) begin
                    ovf_d = 1'b1;
                end
                if (beat && !cfg_abort) begin
                    // Saturate so an all-ones length never wraps back to zero.
                    if (count_q != '1) begin
                        count_d = count_q + LENGTH_WIDTH'(1);
                    end
                    if (count_q == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cfg_abort) begin
            state_d = StIdle;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q   <= StIdle;
            trigger_q <= 1'b0;
            len_q     <= '0;
            hold_q    <= '0;
            hcnt_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trigger_q <= trigger;
            len_q     <= len_d;
            hold_q    <= hold_d;
            hcnt_q    <= hcnt_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign adc_valid_out = (state_q == StCapture && !cfg_abort) ? adc_valid_in : '0;
    assign capture_busy  = busy_q;
    assign capture_done  = done_q;
    assign capture_ovf   = ovf_q;
    assign capture_count = count_q;

endmodule

// File: tb/tb_axi_adc_jesd204_capture_ctrl.sv
// Directed bench for axi_adc_jesd204_capture_ctrl: a per-cycle vector table plus
// hand-written sequences for trigger, sparse-valid, holdoff re-arm and reset cases.
module tb_axi_adc_jesd204_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, abort, mode, trig, dovf;
    logic [15:0] len;
    logic [7:0]  hold;
    logic [1:0]  vin;
    logic [1:0]  vout;
    logic        busy, done, ovf;
    logic [15:0] cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_adc_jesd204_capture_ctrl #(
        .NUM_CHANNELS (2),
        .LENGTH_WIDTH (16),
        .HOLDOFF_WIDTH(8)
    ) dut (
        .adc_clk      (clk),
        .adc_rst      (rst),
        .cfg_arm      (arm),
        .cfg_abort    (abort),
        .cfg_trig_mode(mode),
        .cfg_length   (len),
        .cfg_holdoff  (hold),
        .trigger      (trig),
        .adc_valid_in (vin),
        .adc_dovf     (dovf),
        .adc_valid_out(vout),
        .capture_busy (busy),
        .capture_done (done),
        .capture_ovf  (ovf),
        .capture_count(cnt)
    );

    typedef struct {
        logic        arm, abort;
        logic [15:0] len;
        logic [7:0]  hold;
        logic [1:0]  vin;
        logic        dovf;
        logic [1:0]  e_vout;
        logic        e_busy, e_done, e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic a, ab, input logic [15:0] l, input logic [7:0] h,
                                input logic [1:0] vi, input logic dv, input logic [1:0] evo,
                                input logic eb, ed, eo, input logic [15:0] ec);
        vec_t v;
        v.arm = a;  v.abort = ab; v.len = l; v.hold = h; v.vin = vi; v.dovf = dv;
        v.e_vout = evo; v.e_busy = eb; v.e_done = ed; v.e_ovf = eo; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle before the caller samples.
    task automatic cyc(input logic a, ab, m, input logic [15:0] l, input logic [7:0] h,
                       input logic t, input logic [1:0] vi, input logic dv);
        @(negedge clk);
        arm = a; abort = ab; mode = m; len = l; hold = h; trig = t; vin = vi; dovf = dv;
        #1;
    endtask

    initial begin
        int passed, ch0, ch1, busy_cnt;
        bit seen;

        rst = 1'b1;
        repeat (2) cyc(0, 0, 0, 16'd5, 8'd3, 1'b1, 2'b11, 1'b1);
        chk("reset vout", 32'(vout), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset ovf", 32'(ovf), 0);
        chk("reset count", 32'(cnt), 0);
        rst = 1'b0;
        cyc(0, 0, 0, 16'd0, 8'd0, 1'b0, 2'b00, 1'b0);

        // arm abort len hold vin dovf | vout busy done ovf count
        vecs.push_back(mk(1, 0, 3, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b11, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b11, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b11, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b11, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b00, 1, 1, 0, 4));
        vecs.push_back(mk(0, 0, 3, 0, 2'b11, 0, 2'b00, 0, 0, 0, 4));
        vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 2'b11, 1, 2'b11, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'b11, 0, 2'b11, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 2'b01, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 7, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 7, 0, 2'b11, 0, 2'b11, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 2'b11, 0, 2'b11, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 7, 0, 2'b11, 0, 2'b00, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 7, 0, 2'b11, 0, 2'b00, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 7, 0, 2'b00, 0, 2'b00, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 5, 0, 2'b00, 0, 2'b00, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 5, 0, 2'b11, 0, 2'b00, 0, 0, 0, 2));

        foreach (vecs[i]) begin
            cyc(vecs[i].arm, vecs[i].abort, 1'b0, vecs[i].len, vecs[i].hold, 1'b0,
                vecs[i].vin, vecs[i].dovf);
            chk($sformatf("vec%0d vout", i), 32'(vout), 32'(vecs[i].e_vout));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d count", i), 32'(cnt), 32'(vecs[i].e_cnt));
        end

        // External trigger, holdoff 5; trigger already high at arm must not fire.
        repeat (3) cyc(0, 0, 1, 16'd2, 8'd5, 1'b1, 2'b11, 1'b0);
        cyc(1, 0, 1, 16'd2, 8'd5, 1'b1, 2'b11, 1'b0);
        repeat (3) begin
            cyc(0, 0, 1, 16'd2, 8'd5, 1'b1, 2'b11, 1'b0);
            chk("ext pre-edge vout", 32'(vout), 0);
            chk("ext pre-edge busy", 32'(busy), 1);
        end
        repeat (2) begin
            cyc(0, 0, 1, 16'd9, 8'd0, 1'b0, 2'b11, 1'b0);
            chk("ext trig low vout", 32'(vout), 0);
        end
        cyc(0, 0, 1, 16'd9, 8'd0, 1'b1, 2'b11, 1'b0);
        chk("ext edge-cycle vout", 32'(vout), 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 1, 16'd9, 8'd0, 1'b1, 2'b11, 1'b0);
            chk($sformatf("ext holdoff T+%0d vout", k), 32'(vout), 0);
        end
        cyc(0, 0, 1, 16'd9, 8'd0, 1'b1, 2'b11, 1'b0);
        chk("ext T+6 vout", 32'(vout), 32'(2'b11));
        passed = (vout != 0) ? 1 : 0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 1, 16'd9, 8'd0, 1'b1, 2'b11, 1'b0);
            if (vout != 0) passed++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("ext done seen", 32'(seen), 1);
        chk("ext beats passed", 32'(passed), 3);
        chk("ext count", 32'(cnt), 3);
        cyc(0, 0, 0, 16'd0, 8'd0, 1'b0, 2'b00, 1'b0);

        // Sparse valid on channel 0 only, length 10.
        cyc(1, 0, 0, 16'd9, 8'd0, 1'b0, 2'b00, 1'b0);
        ch0 = 0; ch1 = 0; busy_cnt = 0; seen = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(0, 0, 0, 16'd9, 8'd0, 1'b0, (k % 3 == 0) ? 2'b01 : 2'b00, 1'b0);
            ch0 += int'(vout[0]);
            ch1 += int'(vout[1]);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("sparse done seen", 32'(seen), 1);
        chk("sparse ch0 beats", 32'(ch0), 10);
        chk("sparse ch1 beats", 32'(ch1), 0);
        chk("sparse busy cycles", 32'(busy_cnt), 29);
        chk("sparse count", 32'(cnt), 10);
        cyc(0, 0, 0, 16'd0, 8'd0, 1'b0, 2'b00, 1'b0);
        chk("sparse idle busy", 32'(busy), 0);

        // Re-arm during holdoff with a different config is ignored.
        cyc(1, 0, 0, 16'd1, 8'd4, 1'b0, 2'b11, 1'b0);
        chk("holdoff arm-cycle vout", 32'(vout), 0);
        cyc(1, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("holdoff rearm vout", 32'(vout), 0);
        chk("holdoff rearm busy", 32'(busy), 1);
        repeat (3) begin
            cyc(0, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
            chk("holdoff wait vout", 32'(vout), 0);
        end
        cyc(0, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("holdoff first beat", 32'(vout), 32'(2'b11));
        cyc(0, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("holdoff second beat", 32'(vout), 32'(2'b11));
        cyc(0, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("holdoff done", 32'(done), 1);
        chk("holdoff done vout", 32'(vout), 0);
        chk("holdoff count", 32'(cnt), 2);
        cyc(0, 0, 0, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("holdoff idle busy", 32'(busy), 0);

        // Reset asserted mid-capture.
        cyc(1, 0, 0, 16'd20, 8'd0, 1'b0, 2'b11, 1'b0);
        cyc(0, 0, 0, 16'd20, 8'd0, 1'b0, 2'b11, 1'b1);
        cyc(0, 0, 0, 16'd20, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("midrst pre count", 32'(cnt), 1);
        rst = 1'b1;
        cyc(0, 0, 0, 16'd20, 8'd0, 1'b0, 2'b11, 1'b0);
        rst = 1'b0;
        cyc(0, 0, 0, 16'd20, 8'd0, 1'b0, 2'b11, 1'b0);
        chk("midrst vout", 32'(vout), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst ovf", 32'(ovf), 0);
        chk("midrst count", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
